// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;
  localparam int MEM_SW = 4;

  localparam logic [MEM_DW-1:0] MEM_ARB_ERR_DATA = 32'hDEAD_BEEF;

  // Winner index; prefer_m1 only matters when both masters request.
  function automatic logic arb_pick(input logic v0, input logic v1, input logic prefer_m1);
    logic pick_v;
    if (v0 && v1) begin
      pick_v = prefer_m1;
    end else begin
      pick_v = v1;
    end
    return pick_v;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Transaction watchdog: clearable up-counter with a terminal-count flag at TIMEOUT_CYCLES-1.
module mem_arb_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_r;

  // Count BUSY cycles; cleared while the arbiter sits idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + CW'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == CNT_LAST);

endmodule

// File: rtl/mem_arbiter_2p.sv
// Two-master arbiter for a single-ported valid/ready RAM, one locked transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module mem_arbiter_2p
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_mem_valid,
  output logic              m0_mem_ready,
  input  logic [MEM_AW-1:0] m0_mem_addr,
  input  logic [MEM_DW-1:0] m0_mem_wdata,
  input  logic [MEM_SW-1:0] m0_mem_wstrb,
  output logic [MEM_DW-1:0] m0_mem_rdata,
  input  logic              m1_mem_valid,
  output logic              m1_mem_ready,
  input  logic [MEM_AW-1:0] m1_mem_addr,
  input  logic [MEM_DW-1:0] m1_mem_wdata,
  input  logic [MEM_SW-1:0] m1_mem_wstrb,
  output logic [MEM_DW-1:0] m1_mem_rdata,
  output logic              s_mem_valid,
  input  logic              s_mem_ready,
  output logic [MEM_AW-1:0] s_mem_addr,
  output logic [MEM_DW-1:0] s_mem_wdata,
  output logic [MEM_SW-1:0] s_mem_wstrb,
  input  logic [MEM_DW-1:0] s_mem_rdata,
  output logic              grant,
  output logic              busy,
  output logic              timeout_err
);

  arb_state_t state_r;
  logic       grant_r;
  logic       timeout_err_r;
  logic       busy_s;
  logic       any_req_s;
  logic       grant_nxt_s;
  logic       tc_s;
  logic       timeout_s;
  logic       done_s;
  logic [MEM_DW-1:0] rdata_s;

`ifdef MEM_ARB_RR_EN
  logic rr_last_r;  // last granted master; reset to m1 so m0 wins the first tie
  assign grant_nxt_s = arb_pick(m0_mem_valid, m1_mem_valid, ~rr_last_r);
`else
  assign grant_nxt_s = arb_pick(m0_mem_valid, m1_mem_valid, 1'b0);
`endif

  assign busy_s    = (state_r == ST_BUSY);
  assign any_req_s = m0_mem_valid | m1_mem_valid;
  // A slave completion in the terminal cycle wins over the timeout.
  assign timeout_s = busy_s & tc_s & ~s_mem_ready;
  assign done_s    = busy_s & (s_mem_ready | tc_s);

  mem_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rstn (rstn),
    .clr  (~busy_s),
    .en   (busy_s & ~done_s),
    .tc   (tc_s)
  );

  // Transaction FSM: grant in IDLE, hold until slave completion or timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r       <= ST_IDLE;
      grant_r       <= 1'b0;
      timeout_err_r <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_last_r     <= 1'b1;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            state_r   <= ST_BUSY;
            grant_r   <= grant_nxt_s;
`ifdef MEM_ARB_RR_EN
            rr_last_r <= grant_nxt_s;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (s_mem_ready) begin
            state_r <= ST_IDLE;
          end else if (tc_s) begin
            state_r       <= ST_IDLE;
            timeout_err_r <= 1'b1;
          end else begin
            state_r <= ST_BUSY;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Datapath mux: slave request from the granted master, completion routed back to it.
  always_comb begin
    s_mem_valid  = 1'b0;
    s_mem_addr   = {MEM_AW{1'b0}};
    s_mem_wdata  = {MEM_DW{1'b0}};
    s_mem_wstrb  = {MEM_SW{1'b0}};
    m0_mem_ready = 1'b0;
    m1_mem_ready = 1'b0;
    m0_mem_rdata = {MEM_DW{1'b0}};
    m1_mem_rdata = {MEM_DW{1'b0}};
    rdata_s      = timeout_s ? MEM_ARB_ERR_DATA : s_mem_rdata;
    if (busy_s) begin
      s_mem_valid = 1'b1;
      if (grant_r) begin
        s_mem_addr   = m1_mem_addr;
        s_mem_wdata  = m1_mem_wdata;
        s_mem_wstrb  = m1_mem_wstrb;
        m1_mem_ready = done_s;
        m1_mem_rdata = rdata_s;
      end else begin
        s_mem_addr   = m0_mem_addr;
        s_mem_wdata  = m0_mem_wdata;
        s_mem_wstrb  = m0_mem_wstrb;
        m0_mem_ready = done_s;
        m0_mem_rdata = rdata_s;
      end
    end else begin
      s_mem_valid = 1'b0;
    end
  end

  assign grant       = grant_r;
  assign busy        = busy_s;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Self-checking bench for mem_arbiter_2p: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arbiter_2p;

  localparam int T = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic        clk, rstn;
  logic        m0_mem_valid, m0_mem_ready, m1_mem_valid, m1_mem_ready;
  logic [31:0] m0_mem_addr, m0_mem_wdata, m0_mem_rdata;
  logic [31:0] m1_mem_addr, m1_mem_wdata, m1_mem_rdata;
  logic [3:0]  m0_mem_wstrb, m1_mem_wstrb, s_mem_wstrb;
  logic        s_mem_valid, s_mem_ready;
  logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata;
  logic        grant, busy, timeout_err;

  mem_arbiter_2p #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rstn(rstn),
    .m0_mem_valid(m0_mem_valid), .m0_mem_ready(m0_mem_ready), .m0_mem_addr(m0_mem_addr),
    .m0_mem_wdata(m0_mem_wdata), .m0_mem_wstrb(m0_mem_wstrb), .m0_mem_rdata(m0_mem_rdata),
    .m1_mem_valid(m1_mem_valid), .m1_mem_ready(m1_mem_ready), .m1_mem_addr(m1_mem_addr),
    .m1_mem_wdata(m1_mem_wdata), .m1_mem_wstrb(m1_mem_wstrb), .m1_mem_rdata(m1_mem_rdata),
    .s_mem_valid(s_mem_valid), .s_mem_ready(s_mem_ready), .s_mem_addr(s_mem_addr),
    .s_mem_wdata(s_mem_wdata), .s_mem_wstrb(s_mem_wstrb), .s_mem_rdata(s_mem_rdata),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM_mem-style slave: answers ram_lat cycles after seeing valid, never when ram_dead.
  logic [31:0] ram [0:15];
  int          ram_lat;
  bit          ram_dead;
  int          wcnt;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_mem_ready <= 1'b0;
      s_mem_rdata <= 32'h0;
      wcnt        <= 0;
      for (int i = 0; i < 16; i++) ram[i] <= (i == 4) ? 32'h1234_5678 : 32'h0;
    end else begin
      s_mem_ready <= 1'b0;
      if (s_mem_valid && !s_mem_ready && !ram_dead) begin
        if (wcnt >= ram_lat) begin
          s_mem_ready <= 1'b1;
          wcnt        <= 0;
          s_mem_rdata <= ram[s_mem_addr[5:2]];
          for (int b = 0; b < 4; b++)
            if (s_mem_wstrb[b]) ram[s_mem_addr[5:2]][8*b +: 8] <= s_mem_wdata[8*b +: 8];
        end else begin
          wcnt <= wcnt + 1;
        end
      end else if (!s_mem_valid) begin
        wcnt <= 0;
      end
    end
  end

  // Transaction-level reference state
  req_t        q0[$], q1[$];
  bit          mute0, mute1;
  logic [31:0] mem_model [0:15];
  int          total, bad, cyc;
  bit          m_busy, m_gnt, m_to, m_last, m_prev, m_err;
  int          m_end;
  logic [31:0] m_rd;
  req_t        m_req;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic req_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_t r;
    r.addr = a; r.wdata = d; r.wstrb = s;
    return r;
  endfunction

  function automatic bit pick(input bit v0, input bit v1, input bit last);
`ifdef MEM_ARB_RR_EN
    if (v0 && v1) return !last;
    return v1;
`else
    return !v0;
`endif
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_gnt = 1'b0; m_to = 1'b0; m_err = 1'b0;
    m_last = 1'b1; m_prev = 1'b0;
    for (int i = 0; i < 16; i++) mem_model[i] = (i == 4) ? 32'h1234_5678 : 32'h0;
  endtask

  task automatic drive();
    m0_mem_valid = (q0.size() > 0) && !mute0;
    m1_mem_valid = (q1.size() > 0) && !mute1;
    {m0_mem_addr, m0_mem_wdata, m0_mem_wstrb} = (q0.size() > 0) ? q0[0] : '0;
    {m1_mem_addr, m1_mem_wdata, m1_mem_wstrb} = (q1.size() > 0) ? q1[0] : '0;
  endtask

  // One clock: check every visible output against the model, then let masters and model react.
  task automatic step();
    bit done;
    bit g;
    int lat_eff;
    int idx;
    @(posedge clk); #1; cyc++;
    done = m_busy && (cyc == m_end);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("s_valid", 32'(s_mem_valid), 32'(m_busy));
    chk("m0_ready", 32'(m0_mem_ready), 32'(done && !m_gnt));
    chk("m1_ready", 32'(m1_mem_ready), 32'(done && m_gnt));
    chk("timeout_err", 32'(timeout_err), 32'(m_err));
    if (m_busy) begin
      chk("grant", 32'(grant), 32'(m_gnt));
      chk("s_addr", s_mem_addr, m_req.addr);
      chk("s_wdata", s_mem_wdata, m_req.wdata);
      chk("s_wstrb", 32'(s_mem_wstrb), 32'(m_req.wstrb));
    end else begin
      chk("grant_idle", 32'(grant), 32'(m_prev));
      chk("s_addr_idle", s_mem_addr, 32'h0);
      chk("s_wstrb_idle", 32'(s_mem_wstrb), 32'h0);
    end
    if (done && (m_to || m_req.wstrb == 4'h0))
      chk("rdata", m_gnt ? m1_mem_rdata : m0_mem_rdata, m_rd);
    if (!(m_busy && !m_gnt)) chk("m0_rdata_zero", m0_mem_rdata, 32'h0);
    if (!(m_busy && m_gnt))  chk("m1_rdata_zero", m1_mem_rdata, 32'h0);

    if (done) begin
      if (m_gnt) void'(q1.pop_front());
      else       void'(q0.pop_front());
    end
    drive();

    if (done) begin
      m_busy = 1'b0;
      if (m_to) m_err = 1'b1;
    end else if (!m_busy && (m0_mem_valid || m1_mem_valid)) begin
      g       = pick(m0_mem_valid, m1_mem_valid, m_last);
      m_gnt   = g; m_last = g; m_prev = g;
      m_req   = g ? q1[0] : q0[0];
      lat_eff = ram_dead ? 1000 : ram_lat + 2;
      m_busy  = 1'b1;
      if (lat_eff > T) begin
        m_to  = 1'b1;
        m_end = cyc + T;
        m_rd  = 32'hDEAD_BEEF;
      end else begin
        m_to  = 1'b0;
        m_end = cyc + lat_eff;
        idx   = int'(m_req.addr[5:2]);
        m_rd  = mem_model[idx];
        for (int b = 0; b < 4; b++)
          if (m_req.wstrb[b]) mem_model[idx][8*b +: 8] = m_req.wdata[8*b +: 8];
      end
    end
  endtask

  task automatic run_until_idle(input int budget, input bit rnd_lat);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_busy) && n < budget) begin
      if (rnd_lat && !m_busy) ram_lat = $urandom_range(0, 3);
      step();
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'h1);
    step();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    mute0 = 1'b0; mute1 = 1'b0;
    ram_lat = 0; ram_dead = 1'b0;
    rstn = 1'b0;
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_s_valid", 32'(s_mem_valid), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_timeout_err", 32'(timeout_err), 32'h0);
    chk("rst_m0_ready", 32'(m0_mem_ready), 32'h0);
    #2 rstn = 1'b1;

    // m0 alone reads the preloaded word
    q0.push_back(mk(32'h0000_0010, 32'h0, 4'h0));
    run_until_idle(100, 1'b0);

    // m1 partial write then read-back
    q1.push_back(mk(32'h0000_0020, 32'hA5A5_A5A5, 4'b0011));
    q1.push_back(mk(32'h0000_0020, 32'h0, 4'h0));
    run_until_idle(100, 1'b0);

    // both masters contend for four transactions each
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(32'(i * 4), 32'h1000_0000 + 32'(i), (i % 2 == 0) ? 4'hF : 4'h0));
      q1.push_back(mk(32'(32 + i * 4), 32'h2000_0000 + 32'(i), (i % 2 == 1) ? 4'hF : 4'h0));
    end
    run_until_idle(200, 1'b0);

    // slave completes in the terminal BUSY cycle: normal completion
    ram_lat = T - 2;
    q0.push_back(mk(32'h0000_0010, 32'h0, 4'h0));
    run_until_idle(100, 1'b0);

    // dead slave: timeout, then sticky error through good traffic
    ram_dead = 1'b1;
    q1.push_back(mk(32'h0000_0004, 32'h0, 4'h0));
    run_until_idle(100, 1'b0);
    ram_dead = 1'b0; ram_lat = 0;
    q0.push_back(mk(32'h0000_0020, 32'h0, 4'h0));
    q1.push_back(mk(32'h0000_0024, 32'h5555_AAAA, 4'hF));
    run_until_idle(100, 1'b0);

    // m0 drops valid in its first BUSY cycle
    ram_lat = 1;
    q0.push_back(mk(32'h0000_0010, 32'h0, 4'h0));
    step();
    mute0 = 1'b1;
    run_until_idle(100, 1'b0);
    mute0 = 1'b0;
    ram_lat = 0;

    // asynchronous reset in the first BUSY cycle of an m1 transaction
    q1.push_back(mk(32'h0000_0008, 32'h0, 4'h0));
    step();
    step();
    #2 rstn = 1'b0;
    #1;
    chk("arst_s_valid", 32'(s_mem_valid), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_grant", 32'(grant), 32'h0);
    chk("arst_m0_ready", 32'(m0_mem_ready), 32'h0);
    chk("arst_m1_ready", 32'(m1_mem_ready), 32'h0);
    chk("arst_timeout_err", 32'(timeout_err), 32'h0);
    mute0 = 1'b1; mute1 = 1'b1;
    drive();
    model_reset();
    @(posedge clk);
    #3 rstn = 1'b1;
    mute0 = 1'b0; mute1 = 1'b0;
    run_until_idle(100, 1'b0);

    // random traffic from both masters with random slave latency
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) != 0)
        q0.push_back(mk({26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
                        ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0));
      if ($urandom_range(0, 3) != 0)
        q1.push_back(mk({26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
                        ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0));
    end
    run_until_idle(2000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
